// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I shared widths and opcode constants
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate decoder, sign-extended from inst[31]
module imm_gen
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] imm32
);

  always_comb begin
    imm32 = '0;
    case (inst[6:0])
      // Shift-immediates keep funct7 in the upper bits; execute masks shamt.
      OP_I_ALU, OP_LOAD, OP_JALR, OP_SYSTEM:
        imm32 = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {inst[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

endmodule

// File: rtl/reg_and_imm.sv
// rtl/reg_and_imm.sv - RV32I decode-stage register file plus immediate generator
module reg_and_imm
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] write_data,
  input  logic            RegWrite,
  output logic [XLEN-1:0] read_data_1,
  output logic [XLEN-1:0] read_data_2,
  output logic [XLEN-1:0] imm32
);

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;

  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign rd  = inst[11:7];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (RegWrite && (rd != '0)) begin
      regs_q[rd] <= write_data;
    end
  end

  // x0 is hardwired on the read side so its storage never matters.
  assign read_data_1 = (rs1 == '0) ? '0 : regs_q[rs1];
  assign read_data_2 = (rs2 == '0) ? '0 : regs_q[rs2];

  imm_gen u_imm_gen (
    .inst  (inst),
    .imm32 (imm32)
  );

endmodule

// File: tb/tb_reg_and_imm.sv
// tb/tb_reg_and_imm.sv - self-checking bench for reg_and_imm
module tb_reg_and_imm;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] write_data;
  logic        RegWrite;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] imm32;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] shadow [32];
  logic [6:0]  ops [11];

  reg_and_imm dut (
    .clk         (clk),
    .rst         (rst),
    .inst        (inst),
    .write_data  (write_data),
    .RegWrite    (RegWrite),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .imm32       (imm32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  // Reference immediate built with arithmetic shifts rather than bit concatenation.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [31:0] sx;
    logic [31:0] r;
    sx = 32'($signed(ins) >>> 31);
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
        r = 32'($signed(ins) >>> 20);
      7'b0100011:
        r = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
      7'b1100011:
        r = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      7'b0110111, 7'b0010111:
        r = ins & 32'hFFFF_F000;
      7'b1101111:
        r = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default:
        r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic write_reg(input logic [4:0] rd, input logic [31:0] data);
    inst       = mk_r(rd, 5'd0, 5'd0);
    write_data = data;
    RegWrite   = 1'b1;
    @(posedge clk);
    #1;
    RegWrite   = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] wd;
    logic        we;

    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};

    rst        = 1'b0;
    inst       = mk_r(5'd0, 5'd0, 5'd0);
    write_data = 32'h0;
    RegWrite   = 1'b0;

    #11;
    check("reset_rd1", read_data_1, 32'h0);
    #1 rst = 1'b1;
    #1;
    check("post_reset_rd1_x0", read_data_1, 32'h0);
    check("post_reset_rd2_x0", read_data_2, 32'h0);

    @(posedge clk);
    #1;
    write_reg(5'd0, 32'hFFFF_FFFF);
    inst = mk_r(5'd0, 5'd0, 5'd0);
    #1;
    check("x0_write_ignored", read_data_1, 32'h0);

    write_reg(5'd5, 32'h1234_5678);
    inst = mk_r(5'd0, 5'd5, 5'd0);
    #1;
    check("x5_rd1", read_data_1, 32'h1234_5678);
    inst = mk_r(5'd0, 5'd0, 5'd5);
    #1;
    check("x5_rd2", read_data_2, 32'h1234_5678);

    inst       = mk_r(5'd7, 5'd7, 5'd7);
    write_data = 32'hA5A5_A5A5;
    RegWrite   = 1'b1;
    #1;
    check("x7_no_bypass", read_data_1, 32'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    check("x7_after_edge_rd1", read_data_1, 32'hA5A5_A5A5);
    check("x7_after_edge_rd2", read_data_2, 32'hA5A5_A5A5);

    #2 rst = 1'b0;
    #1;
    check("async_reset_rd1", read_data_1, 32'h0);
    write_data = 32'hDEAD_BEEF;
    RegWrite   = 1'b1;
    @(posedge clk);
    #1;
    check("write_blocked_in_reset", read_data_1, 32'h0);
    RegWrite = 1'b0;
    rst      = 1'b1;
    inst     = mk_r(5'd0, 5'd5, 5'd0);
    #1;
    check("x5_cleared", read_data_1, 32'h0);

    inst = 32'h0020_8233;
    #1 check("imm_rtype", imm32, 32'h0);
    inst = {12'hFFC, 5'd1, 3'b000, 5'd2, 7'b0010011};
    #1 check("imm_addi_m4", imm32, 32'hFFFF_FFFC);
    inst = {7'b0100000, 5'd5, 5'd1, 3'b101, 5'd2, 7'b0010011};
    #1 check("imm_srai_raw", imm32, 32'h0000_0405);
    inst = {7'b1111111, 5'd3, 5'd2, 3'b010, 5'd0, 7'b0100011};
    #1 check("imm_sw_m32", imm32, 32'hFFFF_FFE0);
    inst = {1'b1, 6'b0, 5'd2, 5'd3, 3'b000, 4'b0, 1'b0, 7'b1100011};
    #1 check("imm_beq_m4096", imm32, 32'hFFFF_F000);
    inst = {20'h12345, 5'd1, 7'b0110111};
    #1 check("imm_lui", imm32, 32'h1234_5000);
    inst = {1'b0, 10'b0, 1'b1, 8'b0, 5'd1, 7'b1101111};
    #1 check("imm_jal_2048", imm32, 32'h0000_0800);
    inst = 32'hFFFF_FFFF;
    #1 check("imm_unknown_op", imm32, 32'h0);

    for (int i = 0; i < 32; i++) shadow[i] = 32'h0;

    for (int i = 0; i < 1000; i++) begin
      rnd  = $urandom();
      wd   = $urandom();
      we   = 1'($urandom_range(0, 1));
      inst = {rnd[31:7], ops[$urandom_range(0, 10)]};
      write_data = wd;
      RegWrite   = we;
      #1;
      check("rand_imm", imm32, ref_imm(inst));
      check("rand_rd1", read_data_1, shadow[inst[19:15]]);
      check("rand_rd2", read_data_2, shadow[inst[24:20]]);
      @(posedge clk);
      if (we && (inst[11:7] != 5'd0)) shadow[inst[11:7]] = wd;
      #1;
    end

    RegWrite = 1'b0;
    for (int r = 0; r < 32; r++) begin
      inst = mk_r(5'd0, 5'(r), 5'(31 - r));
      #1;
      check("final_rd1", read_data_1, shadow[r]);
      check("final_rd2", read_data_2, shadow[31 - r]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
